// File: rtl/md_defs.sv
// Shared multiply/divide definitions: op encodings, default latencies and the
// result record handed from the arithmetic block to the controller.
package md_defs;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    // Multi-cycle ops are the ones that occupy the unit (mult/div family).
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op <= OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_chk.sv
// Simulation-only observer for the mult/div controller; carries no logic.
module muldiv_ctrl_chk (
    input logic clk,
    input logic reset,
    input logic start,
    input logic busy
);

    // A start issued while an operation is running is dropped by the controller.
    a_start_while_busy: assert property (@(posedge clk) disable iff (reset) !(start && busy))
        else $info("muldiv_ctrl: start ignored while busy");

endmodule

// File: rtl/muldiv_ctrl_compute.sv
// Combinational mult/div datapath: produces the full {hi,lo} result of the
// E-stage operands plus a divide-by-zero indication.
module md_compute
    import md_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output md_result_t  result,
    output logic        div_zero
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_ovf_s;
    logic [31:0]        divisor_s;
    logic signed [31:0] dividend_sgn_s;
    logic signed [31:0] divisor_sgn_s;
    logic signed [31:0] quot_sgn_s;
    logic signed [31:0] rem_sgn_s;
    logic [31:0]        quot_uns_s;
    logic [31:0]        rem_uns_s;

    assign div_zero  = (srcB == 32'd0);
    assign div_ovf_s = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);

    // Dividing by 1 instead of 0 or -1 keeps the dividers well defined; for the
    // overflow case it also yields exactly the required quotient 0x80000000, rem 0.
    assign divisor_s = (div_zero || div_ovf_s) ? 32'd1 : srcB;

    assign prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
    assign prod_u = {32'd0, srcA} * {32'd0, srcB};

    assign dividend_sgn_s = srcA;
    assign divisor_sgn_s  = divisor_s;
    assign quot_sgn_s     = dividend_sgn_s / divisor_sgn_s;
    assign rem_sgn_s      = dividend_sgn_s % divisor_sgn_s;
    assign quot_uns_s     = srcA / divisor_s;
    assign rem_uns_s      = srcA % divisor_s;

    // Select the result for the requested operation.
    always_comb begin
        result.hi = 32'd0;
        result.lo = 32'd0;
        case (op)
            OP_MULT: begin
                result.hi = prod_s[63:32];
                result.lo = prod_s[31:0];
            end
            OP_MULTU: begin
                result.hi = prod_u[63:32];
                result.lo = prod_u[31:0];
            end
            OP_DIV: begin
                result.hi = rem_sgn_s;
                result.lo = quot_sgn_s;
            end
            OP_DIVU: begin
                result.hi = rem_uns_s;
                result.lo = quot_uns_s;
            end
            default: begin
                result.hi = 32'd0;
                result.lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// E-stage HI/LO unit: launches multi-cycle mult/div, holds busy for the op
// latency, then commits the latched result to HI/LO in one step.
module muldiv_ctrl
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_result_t       res_q, res_d;
    logic             dz_q, dz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    md_result_t       comp_res_s;
    logic             comp_dz_s;

    md_compute u_compute (
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .result  (comp_res_s),
        .div_zero(comp_dz_s)
    );

    // Next-state: launch from IDLE, count down in RUN, commit on the last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start && is_arith_op(op)) begin
                    state_d = ST_RUN;
                    cnt_d   = is_div_op(op) ? DIV_N : MULT_N;
                    res_d   = comp_res_s;
                    dz_d    = comp_dz_s && is_div_op(op);
                end else if (start && (op == OP_MTHI)) begin
                    hi_d = srcA;
                end else if (start && (op == OP_MTLO)) begin
                    lo_d = srcA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_W'(0);
                    if (!dz_q) begin
                        hi_d = res_q.hi;
                        lo_d = res_q.lo;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_W'(0);
            end
        endcase
    end

    // State and architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_W'(0);
            res_q   <= '{hi: 32'd0, lo: 32'd0};
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign stall = md_use_d & (busy | (start & is_arith_op(op)));
    assign hi    = hi_q;
    assign lo    = lo_q;

    muldiv_ctrl_chk u_chk (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .busy (busy)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases followed by
// random traffic, all compared against a cycle-numbered behavioural model.
module tb_muldiv_ctrl;
    import md_defs::*;

    logic        clk = 1'b0;
    logic        reset, start, md_use_d;
    logic [2:0]  op;
    logic [31:0] srcA, srcB;
    logic        busy, stall;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .md_use_d(md_use_d),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: an operation launched in cycle run_start occupies the unit for
    // cycles run_start+1 .. run_end and commits at the end of run_end.
    int          cyc       = 0;
    int          run_start = -1;
    int          run_end   = -1;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0, p_lo = 32'd0;
    bit          p_skip = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, m;
        logic [63:0] ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 64'd0;
        case (o)
            3'd0: r = sa * sb;
            3'd1: r = ua * ub;
            3'd2: if (b != 32'd0) begin
                q = sa / sb;
                m = sa % sb;
                r = {m[31:0], q[31:0]};
            end
            3'd3: if (b != 32'd0) begin
                r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    task automatic step(input bit rst, input bit s, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b, input bit mu);
        bit exp_busy, exp_stall;
        @(negedge clk);
        reset = rst; start = s; op = o; srcA = a; srcB = b; md_use_d = mu;
        #1;
        exp_busy  = (cyc > run_start) && (cyc <= run_end);
        exp_stall = mu && (exp_busy || (s && (o <= 3'd3)));
        chk("busy",  {31'd0, busy},  {31'd0, exp_busy});
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        @(posedge clk);
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; run_start = -1; run_end = -1;
        end else if (exp_busy) begin
            if (cyc == run_end && !p_skip) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (s) begin
            if (o <= 3'd3) begin
                run_start = cyc;
                run_end   = cyc + ((o >= 3'd2) ? DIV_CYCLES_DEF : MULT_CYCLES_DEF);
                {p_hi, p_lo} = ref_result(o, a, b);
                p_skip = (o >= 3'd2) && (b == 32'd0);
            end else if (o == 3'd4) begin
                m_hi = a;
            end else if (o == 3'd5) begin
                m_lo = a;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit mu);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, mu);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 50)) - 32'd25;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; srcA = 32'd0; srcB = 32'd0; md_use_d = 1'b0;
        repeat (2) @(posedge clk);

        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

        // MULT -2*3 with md_use_d held: stall t..t+5, result at t+6.
        step(1'b0, 1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        idle(5, 1'b1);
        #1;
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

        // Same op with md_use_d low: no stall at all.
        step(1'b0, 1'b1, OP_MULT, 32'd9, 32'd9, 1'b0);
        idle(6, 1'b0);

        // Divide by zero leaves previously written HI/LO alone.
        step(1'b0, 1'b1, OP_MTHI, 32'h11, 32'd0, 1'b0);
        step(1'b0, 1'b1, OP_MTLO, 32'h22, 32'd0, 1'b0);
        step(1'b0, 1'b1, OP_DIV, 32'd55, 32'd0, 1'b0);
        idle(10, 1'b0);
        #1;
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);

        step(1'b0, 1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
        idle(10, 1'b0);
        #1;
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        step(1'b0, 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(10, 1'b0);
        #1;
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        step(1'b0, 1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(10, 1'b0);
        #1;
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0000_0000);

        // Reset at t+3 of a DIV aborts it; nothing lands at t+10.
        step(1'b0, 1'b1, OP_DIV, 32'd1000, 32'd3, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        idle(9, 1'b1);
        #1;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);

        step(1'b0, 1'b1, OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
        #1;
        chk("mtlo_lo", lo, 32'hDEAD_BEEF);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        // Start during RUN is dropped; the MULTU result still lands.
        step(1'b0, 1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b1, OP_DIV, 32'd50, 32'd5, 1'b1);
        step(1'b0, 1'b1, OP_MTHI, 32'h1234, 32'd0, 1'b0);
        idle(2, 1'b0);
        #1;
        chk("multu_hi", hi, 32'd1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        idle(3, 1'b1);

        // Reserved ops do nothing.
        step(1'b0, 1'b1, 3'd6, 32'hAAAA_5555, 32'd3, 1'b1);
        step(1'b0, 1'b1, 3'd7, 32'h5555_AAAA, 32'd3, 1'b1);
        idle(2, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 7)), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
